// File: rtl/game_card_dealer.sv
// Card dealer for the blackjack players: draws ranks from a finite deck with an
// LFSR, strobes each card to the master or slave player and sequences the round.
module game_card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned SUITS     = 4,
    parameter int unsigned DEAL_GAP  = 2
) (
    input  logic       clock,
    input  logic       new_Game,
    input  logic       hitMaster,
    input  logic       standMaster,
    input  logic       finishMaster,
    input  logic       finishSlave,
    output logic [3:0] cardValue4,
    output logic       cardReadyMaster,
    output logic       cardReadySlave,
    output logic       masterTurn,
    output logic       roundOver,
    output logic       deckEmpty,
    output logic [5:0] cardsLeft
);

    localparam int unsigned DECK      = 13 * SUITS;
    localparam int unsigned GAP_W     = $clog2(DEAL_GAP + 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [3:0]  RETRY_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT_MASTER,
        ST_SLAVE_TURN,
        ST_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [2:0]         cnt_q [16];
    logic [2:0]         cnt_d [16];
    logic [5:0]         left_q, left_d;
    logic [3:0]         val_q, val_d;
    logic               rdy_m_q, rdy_m_d;
    logic               rdy_s_q, rdy_s_d;
    logic               empty_q, empty_d;
    logic               turn_q, turn_d;
    logic               over_q, over_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         deal_q, deal_d;
    logic               pend_q, pend_d;
    logic [3:0]         retry_q, retry_d;

    logic               draw_req_c;
    logic               to_master_c;
    logic [3:0]         fb_rank_c;
    logic [3:0]         pick_c;
    logic               accept_c;
    logic [3:0]         card_val_c;

    // Fallback rank: lowest rank still in the deck, used once the retry budget runs out
    always_comb begin
        fb_rank_c = 4'd1;
        for (int r = 13; r >= 1; r--) begin
            if (cnt_q[r] != 3'd0) fb_rank_c = 4'(r);
        end
    end

    // Candidate rank for this cycle and its card value; unused slots 0/14/15 stay empty
    always_comb begin
        pick_c   = (retry_q == RETRY_MAX) ? fb_rank_c : lfsr_q[3:0];
        accept_c = (cnt_q[pick_c] != 3'd0);
        case (pick_c)
            4'd1:                card_val_c = 4'd11;
            4'd11, 4'd12, 4'd13: card_val_c = 4'd10;
            default:             card_val_c = pick_c;
        endcase
    end

    // Round sequencing, draw acceptance and deck bookkeeping
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        cnt_d       = cnt_q;
        left_d      = left_q;
        val_d       = val_q;
        rdy_m_d     = 1'b0;
        rdy_s_d     = 1'b0;
        empty_d     = empty_q;
        gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        deal_d      = deal_q;
        pend_d      = pend_q;
        retry_d     = 4'd0;
        draw_req_c  = 1'b0;
        to_master_c = 1'b0;

        if (gap_q == '0) begin
            case (state_q)
                ST_INIT: begin
                    draw_req_c  = 1'b1;
                    to_master_c = ~deal_q[0];
                end
                ST_WAIT_MASTER: begin
                    if (pend_q) begin
                        draw_req_c  = 1'b1;
                        to_master_c = 1'b1;
                    end else if (finishMaster || standMaster) begin
                        state_d = ST_SLAVE_TURN;
                    end else if (hitMaster) begin
                        draw_req_c  = 1'b1;
                        to_master_c = 1'b1;
                    end
                end
                ST_SLAVE_TURN: begin
                    if (finishSlave) state_d = ST_OVER;
                    else             draw_req_c = 1'b1;
                end
                default: ;
            endcase
        end

        if (draw_req_c) begin
            if (left_q == 6'd0) begin
                empty_d = 1'b1;
                pend_d  = 1'b0;
                state_d = ST_OVER;
            end else if (accept_c) begin
                cnt_d[pick_c] = cnt_q[pick_c] - 3'd1;
                left_d        = left_q - 6'd1;
                val_d         = card_val_c;
                rdy_m_d       = to_master_c;
                rdy_s_d       = ~to_master_c;
                gap_d         = GAP_W'(DEAL_GAP);
                pend_d        = 1'b0;
                if (state_q == ST_INIT) begin
                    deal_d = deal_q + 2'd1;
                    if (deal_q == 2'd3) state_d = ST_WAIT_MASTER;
                end
            end else begin
                retry_d = retry_q + 4'd1;
                pend_d  = (state_q == ST_WAIT_MASTER);
            end
        end

        turn_d = (state_d == ST_WAIT_MASTER);
        over_d = (state_d == ST_OVER);
    end

    // State and output registers with synchronous new-game reset
    always_ff @(posedge clock) begin
        if (new_Game) begin
            state_q <= ST_INIT;
            lfsr_q  <= LFSR_SEED;
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= (r >= 1 && r <= 13) ? 3'(SUITS) : 3'd0;
            end
            left_q  <= 6'(DECK);
            val_q   <= 4'd0;
            rdy_m_q <= 1'b0;
            rdy_s_q <= 1'b0;
            empty_q <= 1'b0;
            turn_q  <= 1'b0;
            over_q  <= 1'b0;
            gap_q   <= '0;
            deal_q  <= 2'd0;
            pend_q  <= 1'b0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            val_q   <= val_d;
            rdy_m_q <= rdy_m_d;
            rdy_s_q <= rdy_s_d;
            empty_q <= empty_d;
            turn_q  <= turn_d;
            over_q  <= over_d;
            gap_q   <= gap_d;
            deal_q  <= deal_d;
            pend_q  <= pend_d;
            retry_q <= retry_d;
        end
    end

    // The forced fallback pick must always succeed while cards remain
    always_ff @(posedge clock) begin
        if (!new_Game && draw_req_c && left_q != 6'd0 && retry_q == RETRY_MAX) begin
            assert (accept_c);
        end
    end

    assign cardValue4      = val_q;
    assign cardReadyMaster = rdy_m_q;
    assign cardReadySlave  = rdy_s_q;
    assign masterTurn      = turn_q;
    assign roundOver       = over_q;
    assign deckEmpty       = empty_q;
    assign cardsLeft       = left_q;

endmodule

// File: tb/tb_game_card_dealer.sv
// Bench for game_card_dealer: directed round steps plus random rounds, checked
// against a deck/player model (value limits per rank, cards left, strobe order).
module tb_game_card_dealer;

    localparam int DEAL_GAP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-suit instance
    logic       new_game, hit, stand, fin_m, fin_s;
    logic [3:0] card;
    logic       rdy_m, rdy_s, mturn, over, empty;
    logic [5:0] cleft;

    // One-suit instance
    logic       ng1, st1;
    logic [3:0] card1;
    logic       rdy_m1, rdy_s1, mturn1, over1, empty1;
    logic [5:0] cleft1;

    game_card_dealer dut (
        .clock(clk), .new_Game(new_game), .hitMaster(hit), .standMaster(stand),
        .finishMaster(fin_m), .finishSlave(fin_s), .cardValue4(card),
        .cardReadyMaster(rdy_m), .cardReadySlave(rdy_s), .masterTurn(mturn),
        .roundOver(over), .deckEmpty(empty), .cardsLeft(cleft)
    );

    game_card_dealer #(.SUITS(1)) dut1 (
        .clock(clk), .new_Game(ng1), .hitMaster(1'b0), .standMaster(st1),
        .finishMaster(1'b0), .finishSlave(1'b0), .cardValue4(card1),
        .cardReadyMaster(rdy_m1), .cardReadySlave(rdy_s1), .masterTurn(mturn1),
        .roundOver(over1), .deckEmpty(empty1), .cardsLeft(cleft1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Player and deck model for the four-suit instance
    int mthr = 99, sthr = 99;
    int mtot, stot, dealt, nm, ns, cyc, last;
    int vcnt [16];
    logic [4:0] seq [$];

    assign fin_m = (mtot >= mthr);
    assign fin_s = (stot >= sthr);

    function automatic int val_limit(input int v, input int suits);
        return (v == 10) ? 4 * suits : suits;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (new_game) begin
            mtot = 0; stot = 0; dealt = 0; nm = 0; ns = 0; last = -100;
            for (int i = 0; i < 16; i++) vcnt[i] = 0;
            seq.delete();
        end else if (rdy_m || rdy_s) begin
            int v;
            v = int'(card);
            chk("single_strobe", int'(rdy_m && rdy_s), 0);
            chk("strobe_spacing", int'(cyc - last >= DEAL_GAP + 1), 1);
            chk("value_range", int'(v >= 2 && v <= 11), 1);
            vcnt[v]++;
            chk("rank_supply", int'(vcnt[v] <= val_limit(v, 4)), 1);
            dealt++;
            chk("cards_left", int'(cleft), 52 - dealt);
            seq.push_back({rdy_s, card});
            if (rdy_m) begin nm++; mtot += v; end
            else       begin ns++; stot += v; end
            last = cyc;
        end
    end

    // Deck tally for the one-suit instance
    int n1, n1m;
    int v1cnt [16];
    always @(negedge clk) begin
        if (ng1) begin
            n1 = 0; n1m = 0;
            for (int i = 0; i < 16; i++) v1cnt[i] = 0;
        end else if (rdy_m1 || rdy_s1) begin
            n1++;
            if (rdy_m1) n1m++;
            v1cnt[card1]++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic reset4();
        at_pos(); new_game = 1'b1;
        at_pos(); new_game = 1'b0;
        tick();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy_m"}, int'(rdy_m), 0);
        chk({tag, "_rdy_s"}, int'(rdy_s), 0);
        chk({tag, "_card"}, int'(card), 0);
        chk({tag, "_mturn"}, int'(mturn), 0);
        chk({tag, "_over"}, int'(over), 0);
        chk({tag, "_empty"}, int'(empty), 0);
        chk({tag, "_cleft"}, int'(cleft), 52);
    endtask

    initial begin
        int b, k;
        logic [4:0] ref4 [4];

        new_game = 1'b1; hit = 1'b0; stand = 1'b0;
        ng1 = 1'b1; st1 = 1'b1;

        // Round 1: reset state and initial deal
        reset4();
        check_idle("reset1");
        for (b = 0; b < 200 && !mturn; b++) tick();
        chk("deal1_masterturn", int'(mturn), 1);
        chk("deal1_count", seq.size(), 4);
        chk("deal1_cleft", int'(cleft), 48);
        for (int i = 0; i < 4; i++) begin
            ref4[i] = (seq.size() > i) ? seq[i] : 5'd0;
            chk("deal1_order", int'(ref4[i][4]), i % 2);
        end

        // Three hits, each after the previous card has settled
        for (int h = 0; h < 3; h++) begin
            k = nm;
            repeat (3) at_pos();
            hit = 1'b1; at_pos(); hit = 1'b0;
            for (b = 0; b < 60 && nm == k; b++) tick();
            chk("hit_strobe", nm, k + 1);
        end

        // Hit inside the post-strobe gap is dropped
        k = nm;
        at_pos(); hit = 1'b1; at_pos(); hit = 1'b0;
        repeat (20) tick();
        chk("gap_hit_ignored", nm, k);
        chk("gap_masterturn", int'(mturn), 1);

        // Hit and stand together: stand wins, slave plays to its threshold
        sthr = 17;
        k = nm;
        at_pos(); hit = 1'b1; stand = 1'b1; at_pos(); hit = 1'b0; stand = 1'b0;
        for (b = 0; b < 500 && !over; b++) tick();
        chk("stand_over", int'(over), 1);
        chk("stand_no_master", nm, k);
        chk("stand_slave_done", int'(fin_s), 1);
        chk("stand_masterturn", int'(mturn), 0);
        k = ns;
        repeat (20) tick();
        chk("over_quiet", ns, k);

        // Round 2: same seed gives the same opening deal; reset mid slave turn
        mthr = 99; sthr = 99;
        reset4();
        check_idle("reset2");
        for (b = 0; b < 200 && !mturn; b++) tick();
        chk("deal2_count", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("deal2_replay", int'((seq.size() > i) ? seq[i] : 5'd0), int'(ref4[i]));
        repeat (2) at_pos();
        stand = 1'b1; at_pos(); stand = 1'b0;
        for (b = 0; b < 60 && ns < 3; b++) tick();
        chk("slave_turn_card", ns, 3);
        at_pos(); new_game = 1'b1;
        at_pos(); new_game = 1'b0;
        tick();
        check_idle("midreset");
        for (b = 0; b < 200 && !mturn; b++) tick();
        chk("deal3_count", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("deal3_replay", int'((seq.size() > i) ? seq[i] : 5'd0), int'(ref4[i]));

        // One-suit deck runs dry with a slave that never finishes
        at_pos(); ng1 = 1'b0;
        for (b = 0; b < 1000 && !over1; b++) tick();
        chk("dry_over", int'(over1), 1);
        chk("dry_empty", int'(empty1), 1);
        chk("dry_cleft", int'(cleft1), 0);
        chk("dry_total", n1, 13);
        chk("dry_master", n1m, 2);
        for (int v = 2; v <= 11; v++)
            chk("dry_value_count", v1cnt[v], (v == 10) ? 4 : 1);

        // Random rounds against threshold players
        for (int r = 0; r < 20; r++) begin
            mthr = $urandom_range(21, 12);
            sthr = $urandom_range(21, 12);
            reset4();
            for (b = 0; b < 3000 && !over; b++) begin
                at_pos();
                hit   = ($urandom % 3 == 0);
                stand = ($urandom % 10 == 0);
            end
            hit = 1'b0; stand = 1'b0;
            tick();
            chk("rand_over", int'(over), 1);
            chk("rand_empty", int'(empty), 0);
            chk("rand_cleft", int'(cleft), 52 - dealt);
            chk("rand_aces", int'(vcnt[11] <= 4), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
